// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for data memory and I/O.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic             req0_we_i,
   input  logic [W-1:0]     req0_addr_i,
   input  logic [W-1:0]     req0_wdata_i,
   input  logic [1:0]       req0_size_i,
   input  logic             req0_unsigned_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic             req1_we_i,
   input  logic [W-1:0]     req1_addr_i,
   input  logic [W-1:0]     req1_wdata_i,
   input  logic [1:0]       req1_size_i,
   input  logic             req1_unsigned_i,
   output logic             rsp0_valid_o,
   output logic [W-1:0]     rsp0_rdata_o,
   output logic             rsp0_err_o,
   output logic             rsp1_valid_o,
   output logic [W-1:0]     rsp1_rdata_o,
   output logic             rsp1_err_o,
   output logic             mem_st_en_o,
   output logic [W-1:0]     mem_addr_o,
   output logic [W-1:0]     mem_st_data_o,
   output logic [1:0]       mem_sel_mod_o,
   output logic             mem_unsigned_o,
   input  logic [W-1:0]     mem_ld_data_i,
   output logic [CNT_W-1:0] perf_gnt0_o,
   output logic [CNT_W-1:0] perf_gnt1_o,
   output logic [CNT_W-1:0] perf_conflict_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state;
   logic          last_gnt;
   logic          port_q;
   logic          we_q;
   logic          uns_q;
   logic          err_q;
   logic [1:0]    size_q;
   logic [W-1:0]  addr_q;
   logic [W-1:0]  wdata_q;
   logic [W-1:0]  rdata_q;

   logic          any_valid;
   logic          both_valid;
   logic          win;
   logic          sel_we;
   logic          sel_uns;
   logic          sel_err;
   logic [1:0]    sel_size;
   logic [W-1:0]  sel_addr;
   logic [W-1:0]  sel_wdata;

   // Winner selection and access screening for the request about to be accepted
   always_comb begin
      any_valid  = req0_valid_i | req1_valid_i;
      both_valid = req0_valid_i & req1_valid_i;
      win        = both_valid ? ~last_gnt : req1_valid_i;
      sel_we     = win ? req1_we_i       : req0_we_i;
      sel_addr   = win ? req1_addr_i     : req0_addr_i;
      sel_wdata  = win ? req1_wdata_i    : req0_wdata_i;
      sel_size   = win ? req1_size_i     : req0_size_i;
      sel_uns    = win ? req1_unsigned_i : req0_unsigned_i;
      sel_err    = (sel_size == 2'b11)
                 | ((sel_size == 2'b01) & sel_addr[0])
                 | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
                 | (|sel_addr[W-1:12])
                 | (sel_addr[11:8] >= 4'hA)
                 | (sel_we & (sel_addr[11:8] == 4'h9));
   end

   assign req0_ready_o = (state == IDLE) & ~rst_i & any_valid & ~win;
   assign req1_ready_o = (state == IDLE) & ~rst_i & any_valid &  win;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  port_q   <= win;
                  last_gnt <= win;
                  we_q     <= sel_we;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  size_q   <= sel_size;
                  uns_q    <= sel_uns;
                  err_q    <= sel_err;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q <= (we_q | err_q) ? '0 : mem_ld_data_i;
               state   <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_st_en_o    = (state == ACCESS) & we_q & ~err_q & ~rst_i;
   assign mem_addr_o     = addr_q;
   assign mem_st_data_o  = wdata_q;
   assign mem_sel_mod_o  = size_q;
   assign mem_unsigned_o = uns_q;

   assign rsp0_valid_o = (state == RESP) & ~port_q & ~rst_i;
   assign rsp1_valid_o = (state == RESP) &  port_q & ~rst_i;
   assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
   assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;
   assign rsp0_err_o   = rsp0_valid_o & err_q;
   assign rsp1_err_o   = rsp1_valid_o & err_q;

`ifdef DMEM_ARB_PERF_EN
   logic [CNT_W-1:0] gnt0_cnt;
   logic [CNT_W-1:0] gnt1_cnt;
   logic [CNT_W-1:0] conflict_cnt;

   // Counters wrap naturally at 2^CNT_W
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt0_cnt     <= '0;
         gnt1_cnt     <= '0;
         conflict_cnt <= '0;
      end else if (state == IDLE) begin
         if (any_valid & ~win) gnt0_cnt <= gnt0_cnt + 1'b1;
         if (any_valid &  win) gnt1_cnt <= gnt1_cnt + 1'b1;
         if (both_valid)       conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   assign perf_gnt0_o     = gnt0_cnt;
   assign perf_gnt1_o     = gnt1_cnt;
   assign perf_conflict_o = conflict_cnt;
`else
   assign perf_gnt0_o     = '0;
   assign perf_gnt1_o     = '0;
   assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares whenever a response pulse appears.
module tb_dmem_arbiter;

   localparam int W     = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             req0_valid_i = 1'b0, req0_we_i = 1'b0, req0_unsigned_i = 1'b0;
   logic             req1_valid_i = 1'b0, req1_we_i = 1'b0, req1_unsigned_i = 1'b0;
   logic [W-1:0]     req0_addr_i = '0, req0_wdata_i = '0;
   logic [W-1:0]     req1_addr_i = '0, req1_wdata_i = '0;
   logic [1:0]       req0_size_i = 2'b00, req1_size_i = 2'b00;
   logic [W-1:0]     mem_ld_data_i = '0;
   logic             req0_ready_o, req1_ready_o;
   logic             rsp0_valid_o, rsp0_err_o, rsp1_valid_o, rsp1_err_o;
   logic [W-1:0]     rsp0_rdata_o, rsp1_rdata_o;
   logic             mem_st_en_o, mem_unsigned_o;
   logic [W-1:0]     mem_addr_o, mem_st_data_o;
   logic [1:0]       mem_sel_mod_o;
   logic [CNT_W-1:0] perf_gnt0_o, perf_gnt1_o, perf_conflict_o;

   typedef struct {
      logic         port;
      logic [W-1:0] rdata;
      logic         err;
   } exp_t;

   exp_t sbq[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   st_pulses = 0;

   dmem_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
      .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i), .req0_size_i(req0_size_i),
      .req0_unsigned_i(req0_unsigned_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
      .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i), .req1_size_i(req1_size_i),
      .req1_unsigned_i(req1_unsigned_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
      .mem_st_en_o(mem_st_en_o), .mem_addr_o(mem_addr_o), .mem_st_data_o(mem_st_data_o),
      .mem_sel_mod_o(mem_sel_mod_o), .mem_unsigned_o(mem_unsigned_o),
      .mem_ld_data_i(mem_ld_data_i),
      .perf_gnt0_o(perf_gnt0_o), .perf_gnt1_o(perf_gnt1_o), .perf_conflict_o(perf_conflict_o)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst_i) begin
         if (mem_st_en_o) st_pulses++;
         if (rsp0_valid_o && rsp1_valid_o) begin
            n_total++;
            $display("[TB] FAIL rsp_both: got both valid, expected one");
         end else if (rsp0_valid_o || rsp1_valid_o) begin
            if (sbq.size() == 0) begin
               n_total++;
               $display("[TB] FAIL rsp_unexpected: got response on port %0d, expected none", rsp1_valid_o);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check_output("rsp_port", {31'd0, rsp1_valid_o}, {31'd0, e.port});
               check_output("rsp_rdata", rsp1_valid_o ? rsp1_rdata_o : rsp0_rdata_o, e.rdata);
               check_output("rsp_err", {31'd0, rsp1_valid_o ? rsp1_err_o : rsp0_err_o}, {31'd0, e.err});
            end
         end else begin
            check_output("rsp_idle_zero",
               {31'd0, (|rsp0_rdata_o) | rsp0_err_o | (|rsp1_rdata_o) | rsp1_err_o}, 32'd0);
         end
      end
   end

   task automatic set_req(input bit port, input bit v, input bit we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input logic [1:0] size, input bit uns);
      if (port) begin
         req1_valid_i = v; req1_we_i = we; req1_addr_i = addr;
         req1_wdata_i = wdata; req1_size_i = size; req1_unsigned_i = uns;
      end else begin
         req0_valid_i = v; req0_we_i = we; req0_addr_i = addr;
         req0_wdata_i = wdata; req0_size_i = size; req0_unsigned_i = uns;
      end
   endtask

   // Issue one request, check accept and ACCESS-cycle memory signals, queue the response
   task automatic apply_stimulus(input bit port, input bit we, input logic [W-1:0] addr,
                                 input logic [W-1:0] wdata, input logic [1:0] size, input bit uns,
                                 input logic [W-1:0] ld, input logic [W-1:0] exp_rdata,
                                 input bit exp_err);
      int   n;
      bit   got;
      exp_t e;
      mem_ld_data_i = ld;
      set_req(port, 1'b1, we, addr, wdata, size, uns);
      n = 0; got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         if (port ? req1_ready_o : req0_ready_o) got = 1;
         else n++;
      end
      if (!got) begin
         n_total++;
         $display("[TB] FAIL ready_timeout: got no ready on port %0d, expected ready", port);
         set_req(port, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
         return;
      end
      check_output("ready_other", {31'd0, port ? req0_ready_o : req1_ready_o}, 32'd0);
      e.port = port; e.rdata = exp_rdata; e.err = exp_err;
      sbq.push_back(e);
      @(posedge clk); #1;
      set_req(port, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      @(negedge clk);
      check_output("acc_addr", mem_addr_o, addr);
      check_output("acc_st_data", mem_st_data_o, wdata);
      check_output("acc_sel", {30'd0, mem_sel_mod_o}, {30'd0, size});
      check_output("acc_uns", {31'd0, mem_unsigned_o}, {31'd0, uns});
      check_output("acc_st_en", {31'd0, mem_st_en_o}, {31'd0, we & ~exp_err});
      check_output("acc_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_outs", {26'd0, mem_st_en_o, rsp0_valid_o, rsp1_valid_o,
                                req0_ready_o, req1_ready_o, mem_unsigned_o}, 32'd0);
      check_output("rst_addr", mem_addr_o | mem_st_data_o | {30'd0, mem_sel_mod_o}, 32'd0);
      check_output("rst_perf", {16'd0, perf_gnt0_o | perf_gnt1_o | perf_conflict_o}, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   pulses_before;
      int   gcount;
      int   cyc;
      int   last_cyc;
      int   n;
      bit   g;
      bit   got;
      exp_t e;

      do_reset();

      // Plain accesses and error screening
      apply_stimulus(0, 0, 32'h010, 32'h0, 2'b10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
      pulses_before = st_pulses;
      apply_stimulus(1, 1, 32'h803, 32'hA5, 2'b00, 0, 32'h0, 32'h0, 0);
      check_output("st_byte_pulses", st_pulses - pulses_before, 32'd1);
      pulses_before = st_pulses;
      apply_stimulus(0, 1, 32'h101, 32'h1234, 2'b01, 0, 32'h0, 32'h0, 1);
      apply_stimulus(1, 1, 32'h900, 32'h5678, 2'b10, 0, 32'h0, 32'h0, 1);
      check_output("err_st_pulses", st_pulses - pulses_before, 32'd0);
      apply_stimulus(1, 0, 32'h902, 32'h0, 2'b00, 1, 32'h000000C3, 32'h000000C3, 0);
      apply_stimulus(0, 0, 32'hA00, 32'h0, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1);
      apply_stimulus(0, 0, 32'h004, 32'h0, 2'b11, 0, 32'hFFFFFFFF, 32'h0, 1);
      apply_stimulus(1, 0, 32'h1000, 32'h0, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1);
      apply_stimulus(0, 0, 32'h8FE, 32'h0, 2'b01, 0, 32'h0000BEEF, 32'h0000BEEF, 0);

      // Continuous contention from reset: strict alternation, one accept per 3 cycles
      do_reset();
      pulses_before = st_pulses;
      mem_ld_data_i = 32'hFFFFFFFF;
      set_req(0, 1'b1, 1'b1, 32'h020, 32'h11, 2'b10, 1'b0);
      set_req(1, 1'b1, 1'b1, 32'h024, 32'h22, 2'b10, 1'b0);
      gcount = 0; cyc = 0; last_cyc = 0;
      while (gcount < 4 && cyc < 30) begin
         @(negedge clk);
         if (req0_ready_o || req1_ready_o) begin
            g = req1_ready_o;
            check_output("conf_single", {31'd0, req0_ready_o & req1_ready_o}, 32'd0);
            check_output("conf_order", {31'd0, g}, (gcount % 2 == 1) ? 32'd1 : 32'd0);
            if (gcount > 0) check_output("conf_spacing", cyc - last_cyc, 32'd3);
            e.port = g; e.rdata = '0; e.err = 1'b0;
            sbq.push_back(e);
            last_cyc = cyc;
            gcount++;
         end
         cyc++;
      end
      check_output("conf_grants", gcount, 32'd4);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      set_req(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check_output("conf_st_pulses", st_pulses - pulses_before, 32'd4);
`ifdef DMEM_ARB_PERF_EN
      check_output("perf_conflict", {16'd0, perf_conflict_o}, 32'd4);
      check_output("perf_gnt0", {16'd0, perf_gnt0_o}, 32'd2);
      check_output("perf_gnt1", {16'd0, perf_gnt1_o}, 32'd2);
`else
      check_output("perf_off", {16'd0, perf_gnt0_o | perf_gnt1_o | perf_conflict_o}, 32'd0);
`endif

      // Reset lands in the ACCESS cycle of a port-0 store
      pulses_before = st_pulses;
      set_req(0, 1'b1, 1'b1, 32'h040, 32'h77, 2'b10, 1'b0);
      @(negedge clk);
      check_output("mid_ready0", {31'd0, req0_ready_o}, 32'd1);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      rst_i = 1'b1;
      @(negedge clk);
      check_output("mid_st_en", {31'd0, mem_st_en_o}, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk);
      check_output("mid_addr_cleared", mem_addr_o, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check_output("mid_no_store", st_pulses - pulses_before, 32'd0);

      mem_ld_data_i = 32'h12345678;
      set_req(0, 1'b1, 1'b1, 32'h050, 32'h33, 2'b10, 1'b0);
      set_req(1, 1'b1, 1'b0, 32'h060, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      check_output("post_rst_winner", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
      if (req0_ready_o) begin
         e.port = 1'b0; e.rdata = '0; e.err = 1'b0;
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      n = 0; got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         if (req1_ready_o) got = 1;
         else n++;
      end
      check_output("post_rst_ready1", {31'd0, got}, 32'd1);
      if (got) begin
         e.port = 1'b1; e.rdata = 32'h12345678; e.err = 1'b0;
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      repeat (5) @(posedge clk);
      #1;

      check_output("sb_drained", sbq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
